// File: rtl/adder_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adder_arbiter (with its shared Adder)
// Purpose  : Round-robin arbiter sharing one Adder among NUM_REQ requesters.
//            Optional ADDER_ARB_SUB_EN adds two-pass A-B on the same adder.
// Revision : 1.0  initial release
// ============================================================================

module Adder #(
    parameter int n = 64
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
    parameter  int WIDTH   = 64,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       reqValid,
    output logic [NUM_REQ-1:0]       reqReady,
    input  logic [NUM_REQ*WIDTH-1:0] reqOpA,
    input  logic [NUM_REQ*WIDTH-1:0] reqOpB,
    input  logic [NUM_REQ-1:0]       reqSub,
    output logic                     rspValid,
    input  logic                     rspReady,
    output logic [IDW-1:0]           rspId,
    output logic [WIDTH:0]           rspResult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
`ifdef ADDER_ARB_SUB_EN
        S_INC  = 2'd2,
`endif
        S_RESP = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_last_grant;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;

    logic [IDW-1:0]   w_grant;
    logic             w_any;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

`ifdef ADDER_ARB_SUB_EN
    logic             r_sub;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
`else
    logic             w_unused_sub;
    assign w_unused_sub = ^reqSub;
`endif

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] last, input int k);
        int t;
        t = int'(last) + k;
        if (t >= NUM_REQ) t = t - NUM_REQ;
        return IDW'(t);
    endfunction

    // First valid requester after the last grant, wrapping around.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && reqValid[rr_index(r_last_grant, k)]) begin
                w_any   = 1'b1;
                w_grant = rr_index(r_last_grant, k);
            end
        end
    end

    always_comb begin
        reqReady = '0;
        if (rst_n && (r_state == S_IDLE) && w_any) reqReady[w_grant] = 1'b1;
    end

    always_comb begin
        w_add_a = r_opa;
        w_add_b = r_opb;
`ifdef ADDER_ARB_SUB_EN
        // Second pass completes the two's-complement negation of B.
        if (r_state == S_INC) begin
            w_add_a = r_sum;
            w_add_b = WIDTH'(1);
        end else if (r_sub) begin
            w_add_b = ~r_opb;
        end
`endif
    end

    Adder #(.n(WIDTH)) u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_opa        <= '0;
            r_opb        <= '0;
            rspValid     <= 1'b0;
            rspId        <= '0;
            rspResult    <= '0;
`ifdef ADDER_ARB_SUB_EN
            r_sub        <= 1'b0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        // Only the granted slice is captured, so other slices never reach outputs.
                        r_opa        <= reqOpA[int'(w_grant)*WIDTH +: WIDTH];
                        r_opb        <= reqOpB[int'(w_grant)*WIDTH +: WIDTH];
                        rspId        <= w_grant;
                        r_last_grant <= w_grant;
`ifdef ADDER_ARB_SUB_EN
                        r_sub        <= reqSub[w_grant];
`endif
                        r_state      <= S_ADD;
                    end
                end
                S_ADD: begin
`ifdef ADDER_ARB_SUB_EN
                    if (r_sub) begin
                        r_sum   <= w_sum;
                        r_carry <= w_cout;
                        r_state <= S_INC;
                    end else
`endif
                    begin
                        rspResult <= {w_cout, w_sum};
                        rspValid  <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
`ifdef ADDER_ARB_SUB_EN
                S_INC: begin
                    r_sum     <= w_sum;
                    r_carry   <= r_carry | w_cout;
                    rspResult <= {r_carry | w_cout, w_sum};
                    rspValid  <= 1'b1;
                    r_state   <= S_RESP;
                end
`endif
                S_RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
